// File: rtl/rate_counter_pkg.sv
// Shared definitions for the rate-selectable modulo counter.
//   speed_e      : encoding of the 2-bit Speed select input
//   DEF_*        : default parameter values (50 MHz board timebase)
package rate_counter_pkg;

  typedef enum logic [1:0] {
    SPD_FULL = 2'b00,
    SPD_1    = 2'b01,
    SPD_2    = 2'b10,
    SPD_3    = 2'b11
  } speed_e;

  localparam int              DEF_COUNT_W   = 4;
  localparam int              DEF_MAX_COUNT = 15;
  localparam int              DEF_DIV_W     = 32;
  localparam longint unsigned DEF_PERIOD0   = 64'd1;
  localparam longint unsigned DEF_PERIOD1   = 64'd50000000;
  localparam longint unsigned DEF_PERIOD2   = 64'd100000000;
  localparam longint unsigned DEF_PERIOD3   = 64'd200000000;

endpackage

// File: rtl/rate_counter_multi_divider.sv
// Selectable-period rate divider.
// Ports:
//   ClockIn  - system clock
//   Resetn   - asynchronous active-low reset
//   Enable   - 1 = run, 0 = hold the down-counter mid-period
//   Load     - restarts the period and suppresses Tick
//   Speed    - period select (see speed_e)
//   Tick     - combinational: high in cycles where the counter advances
module rate_divider
  import rate_counter_pkg::*;
#(
  parameter int              DIV_W   = DEF_DIV_W,
  parameter longint unsigned PERIOD0 = DEF_PERIOD0,
  parameter longint unsigned PERIOD1 = DEF_PERIOD1,
  parameter longint unsigned PERIOD2 = DEF_PERIOD2,
  parameter longint unsigned PERIOD3 = DEF_PERIOD3
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Load,
  input  logic [1:0] Speed,
  output logic       Tick
);

  // Reload values are PERIOD-1 so a period of 2^DIV_W still fits in DIV_W bits.
  localparam logic [DIV_W-1:0] RELOAD0 = DIV_W'(PERIOD0 - 64'd1);
  localparam logic [DIV_W-1:0] RELOAD1 = DIV_W'(PERIOD1 - 64'd1);
  localparam logic [DIV_W-1:0] RELOAD2 = DIV_W'(PERIOD2 - 64'd1);
  localparam logic [DIV_W-1:0] RELOAD3 = DIV_W'(PERIOD3 - 64'd1);

  logic [DIV_W-1:0] div_count;
  logic [DIV_W-1:0] reload;
  speed_e           speed_q;
  logic             at_zero;

  always_comb begin
    reload = RELOAD0;
    case (Speed)
      SPD_FULL: reload = RELOAD0;
      SPD_1:    reload = RELOAD1;
      SPD_2:    reload = RELOAD2;
      SPD_3:    reload = RELOAD3;
      default:  reload = RELOAD0;
    endcase
  end

  assign at_zero = (div_count == '0);
  assign Tick    = Enable && !Load && at_zero;

  // speed_q tracks Speed unconditionally so a change made while paused is
  // still seen as a change on the first enabled cycle only if it happens then.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      div_count <= '0;
      speed_q   <= SPD_FULL;
    end else begin
      speed_q <= speed_e'(Speed);
      if (Load) begin
        div_count <= reload;
      end else if (Enable) begin
        // Expiry reload takes priority, so a speed change landing on the tick
        // cycle still ticks and simply reloads with the new period.
        if (at_zero || (Speed != speed_q)) begin
          div_count <= reload;
        end else begin
          div_count <= div_count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rate_counter_multi.sv
// Rate-selectable modulo-N up/down counter with load, pause and wrap pulse.
// Ports:
//   ClockIn      - system clock
//   Resetn       - asynchronous active-low reset
//   Enable       - 1 = run, 0 = pause divider and counter
//   Speed        - tick period select
//   Up           - 1 = count up, 0 = count down
//   Load         - synchronous parallel load (wins over a tick)
//   LoadValue    - value to load, saturated to MAX_COUNT
//   CounterValue - registered count, 0..MAX_COUNT
//   Tick         - combinational advance strobe from the divider
//   Wrap         - registered pulse coincident with the wrapped count value
module rate_counter_multi
  import rate_counter_pkg::*;
#(
  parameter int              COUNT_W   = DEF_COUNT_W,
  parameter int              MAX_COUNT = DEF_MAX_COUNT,
  parameter int              DIV_W     = DEF_DIV_W,
  parameter longint unsigned PERIOD0   = DEF_PERIOD0,
  parameter longint unsigned PERIOD1   = DEF_PERIOD1,
  parameter longint unsigned PERIOD2   = DEF_PERIOD2,
  parameter longint unsigned PERIOD3   = DEF_PERIOD3
) (
  input  logic               ClockIn,
  input  logic               Resetn,
  input  logic               Enable,
  input  logic [1:0]         Speed,
  input  logic               Up,
  input  logic               Load,
  input  logic [COUNT_W-1:0] LoadValue,
  output logic [COUNT_W-1:0] CounterValue,
  output logic               Tick,
  output logic               Wrap
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

  logic [COUNT_W-1:0] count_p1;
  logic               wrap_p1;

  function automatic logic [COUNT_W-1:0] saturate(input logic [COUNT_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  rate_divider #(
    .DIV_W  (DIV_W),
    .PERIOD0(PERIOD0),
    .PERIOD1(PERIOD1),
    .PERIOD2(PERIOD2),
    .PERIOD3(PERIOD3)
  ) u_div (
    .ClockIn(ClockIn),
    .Resetn (Resetn),
    .Enable (Enable),
    .Load   (Load),
    .Speed  (Speed),
    .Tick   (Tick)
  );

  // Stage p1: count and wrap registered on the edge that samples Tick.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      count_p1 <= '0;
      wrap_p1  <= 1'b0;
    end else if (Load) begin
      count_p1 <= saturate(LoadValue);
      wrap_p1  <= 1'b0;
    end else if (Tick) begin
      if (Up) begin
        if (count_p1 == MAX_VAL) begin
          count_p1 <= '0;
          wrap_p1  <= 1'b1;
        end else begin
          count_p1 <= count_p1 + 1'b1;
          wrap_p1  <= 1'b0;
        end
      end else begin
        if (count_p1 == '0) begin
          count_p1 <= MAX_VAL;
          wrap_p1  <= 1'b1;
        end else begin
          count_p1 <= count_p1 - 1'b1;
          wrap_p1  <= 1'b0;
        end
      end
    end else begin
      wrap_p1 <= 1'b0;
    end
  end

  assign CounterValue = count_p1;
  assign Wrap         = wrap_p1;

endmodule
